// File: rtl/lc3_sequencer.sv
// LC-3 control sequencer: Moore FSM decoding datapath strobes from the current state and IR.
// Memory states stretch by MEM_WAIT cycles through a down-counter that loads on entry.
module lc3_sequencer #(
  parameter int unsigned MEM_WAIT = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  output logic [1:0]  aluControl,
  output logic        enaALU,
  output logic        enaMARM,
  output logic        enaMDR,
  output logic        enaPC,
  output logic        selMAR,
  output logic        selEAB1,
  output logic [1:0]  selEAB2,
  output logic        ldPC,
  output logic        ldIR,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic [1:0]  selPC,
  output logic        selMDR,
  output logic [2:0]  SR1,
  output logic [2:0]  SR2,
  output logic [2:0]  DR,
  output logic        regWE,
  output logic        memWE,
  output logic        halted
);

  typedef enum logic [3:0] {
    S_FETCH0, S_FETCH1, S_FETCH2, S_DECODE,
    S_EXEC_ALU, S_EXEC_BR, S_EXEC_JMP, S_EXEC_LEA,
    S_ADDR, S_MEMRD, S_WB, S_MDRLD, S_MEMWR, S_HALT
  } state_t;

  localparam logic [3:0] WAIT_INIT = 4'(MEM_WAIT);

  state_t     state, state_nxt;
  logic [3:0] wait_cnt, wait_nxt;
  logic       wait_done;
  logic [3:0] opcode;
  logic       unused_ir;

  assign opcode    = IR[15:12];
  assign wait_done = (wait_cnt == 4'd0);
  assign unused_ir = ^IR[5:3];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= S_FETCH0;
      wait_cnt <= 4'd0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    wait_nxt   = wait_cnt;
    aluControl = 2'b00;
    enaALU     = 1'b0;
    enaMARM    = 1'b0;
    enaMDR     = 1'b0;
    enaPC      = 1'b0;
    selMAR     = 1'b0;
    selEAB1    = 1'b0;
    selEAB2    = 2'b00;
    ldPC       = 1'b0;
    ldIR       = 1'b0;
    ldMAR      = 1'b0;
    ldMDR      = 1'b0;
    selPC      = 2'b00;
    selMDR     = 1'b0;
    SR1        = 3'd0;
    SR2        = 3'd0;
    DR         = 3'd0;
    regWE      = 1'b0;
    memWE      = 1'b0;
    halted     = 1'b0;
    // Every strobe stays low while reset is held, including the FETCH0 decode.
    if (!reset) begin
      case (state)
        S_FETCH0: begin
          enaPC     = 1'b1;
          ldMAR     = 1'b1;
          ldPC      = 1'b1;
          selPC     = 2'b00;
          state_nxt = S_FETCH1;
          wait_nxt  = WAIT_INIT;
        end
        S_FETCH1: begin
          selMDR = 1'b1;
          if (wait_done) begin
            ldMDR     = 1'b1;
            state_nxt = S_FETCH2;
          end else begin
            wait_nxt = wait_cnt - 4'd1;
          end
        end
        S_FETCH2: begin
          enaMDR    = 1'b1;
          ldIR      = 1'b1;
          state_nxt = S_DECODE;
        end
        S_DECODE: begin
          case (opcode)
            4'b0001, 4'b0101, 4'b1001:          state_nxt = S_EXEC_ALU;
            4'b0000:                            state_nxt = S_EXEC_BR;
            4'b1100:                            state_nxt = S_EXEC_JMP;
            4'b1110:                            state_nxt = S_EXEC_LEA;
            4'b0010, 4'b0110, 4'b0011, 4'b0111: state_nxt = S_ADDR;
            default:                            state_nxt = S_HALT;
          endcase
        end
        S_EXEC_ALU: begin
          enaALU = 1'b1;
          regWE  = 1'b1;
          DR     = IR[11:9];
          SR1    = IR[8:6];
          SR2    = IR[2:0];
          case (opcode)
            4'b0101: aluControl = 2'b01;
            4'b1001: aluControl = 2'b10;
            default: aluControl = 2'b00;
          endcase
          state_nxt = S_FETCH0;
        end
        S_EXEC_BR: begin
          ldPC      = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
          selPC     = 2'b01;
          selEAB2   = 2'b10;
          state_nxt = S_FETCH0;
        end
        S_EXEC_JMP: begin
          ldPC      = 1'b1;
          selPC     = 2'b01;
          selEAB1   = 1'b1;
          SR1       = IR[8:6];
          state_nxt = S_FETCH0;
        end
        S_EXEC_LEA: begin
          enaMARM   = 1'b1;
          selEAB2   = 2'b10;
          regWE     = 1'b1;
          DR        = IR[11:9];
          state_nxt = S_FETCH0;
        end
        S_ADDR: begin
          enaMARM = 1'b1;
          ldMAR   = 1'b1;
          // IR[14] separates base+offset6 (LDR/STR) from PC-relative (LD/ST); IR[12] marks stores.
          if (IR[14]) begin
            selEAB1 = 1'b1;
            selEAB2 = 2'b01;
            SR1     = IR[8:6];
          end else begin
            selEAB2 = 2'b10;
          end
          if (IR[12]) begin
            state_nxt = S_MDRLD;
          end else begin
            state_nxt = S_MEMRD;
            wait_nxt  = WAIT_INIT;
          end
        end
        S_MEMRD: begin
          selMDR = 1'b1;
          if (wait_done) begin
            ldMDR     = 1'b1;
            state_nxt = S_WB;
          end else begin
            wait_nxt = wait_cnt - 4'd1;
          end
        end
        S_WB: begin
          enaMDR    = 1'b1;
          regWE     = 1'b1;
          DR        = IR[11:9];
          state_nxt = S_FETCH0;
        end
        S_MDRLD: begin
          SR1        = IR[11:9];
          aluControl = 2'b11;
          enaALU     = 1'b1;
          ldMDR      = 1'b1;
          state_nxt  = S_MEMWR;
          wait_nxt   = WAIT_INIT;
        end
        S_MEMWR: begin
          memWE = 1'b1;
          if (wait_done) begin
            state_nxt = S_FETCH0;
          end else begin
            wait_nxt = wait_cnt - 4'd1;
          end
        end
        S_HALT: begin
          halted = 1'b1;
        end
        default: state_nxt = S_FETCH0;
      endcase
    end
  end

endmodule

// File: tb/tb_lc3_sequencer.sv
// Bench for lc3_sequencer: two instances (MEM_WAIT 0 and 2), a hand-written vector table,
// reset/halt sequences and random instruction streams against a sequence-level reference model.
module tb_lc3_sequencer;

  typedef struct packed {
    logic [1:0] alu;
    logic       ena_alu;
    logic       ena_marm;
    logic       ena_mdr;
    logic       ena_pc;
    logic       sel_mar;
    logic       sel_eab1;
    logic [1:0] sel_eab2;
    logic       ld_pc;
    logic       ld_ir;
    logic       ld_mar;
    logic       ld_mdr;
    logic [1:0] sel_pc;
    logic       sel_mdr;
    logic [2:0] sr1;
    logic [2:0] sr2;
    logic [2:0] dr;
    logic       reg_we;
    logic       mem_we;
    logic       halted;
  } outs_t;

  typedef struct {
    logic [15:0] ir;
    logic [2:0]  nzp;
    int          d;
    int          len;
    int          idx;
    outs_t       exp;
  } vec_t;

  typedef struct {
    outs_t o;
    bit    br;
  } rec_t;

  logic        clk = 1'b0;
  logic        rst [2];
  logic [15:0] ir  [2];
  logic        n   [2];
  logic        z   [2];
  logic        p   [2];
  outs_t       outs[2];

  int    n_total = 0;
  int    n_bad   = 0;
  vec_t  vecs[$];
  rec_t  exp_q[$];
  outs_t trace[32];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    logic [1:0] alu, sel_eab2, sel_pc;
    logic [2:0] sr1, sr2, dr;
    logic ena_alu, ena_marm, ena_mdr, ena_pc, sel_mar, sel_eab1;
    logic ld_pc, ld_ir, ld_mar, ld_mdr, sel_mdr, reg_we, mem_we, halted;

    lc3_sequencer #(.MEM_WAIT(g * 2)) dut (
      .clk(clk), .reset(rst[g]), .IR(ir[g]), .N(n[g]), .Z(z[g]), .P(p[g]),
      .aluControl(alu), .enaALU(ena_alu), .enaMARM(ena_marm), .enaMDR(ena_mdr),
      .enaPC(ena_pc), .selMAR(sel_mar), .selEAB1(sel_eab1), .selEAB2(sel_eab2),
      .ldPC(ld_pc), .ldIR(ld_ir), .ldMAR(ld_mar), .ldMDR(ld_mdr), .selPC(sel_pc),
      .selMDR(sel_mdr), .SR1(sr1), .SR2(sr2), .DR(dr), .regWE(reg_we),
      .memWE(mem_we), .halted(halted)
    );

    assign outs[g] = {alu, ena_alu, ena_marm, ena_mdr, ena_pc, sel_mar, sel_eab1, sel_eab2,
                      ld_pc, ld_ir, ld_mar, ld_mdr, sel_pc, sel_mdr, sr1, sr2, dr,
                      reg_we, mem_we, halted};
  end

  task automatic check(input string name, input int d, input outs_t got, input outs_t exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s dut=%0d got=%h exp=%h", name, d, got, exp);
    end
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    n_total++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  function automatic void add_vec(input logic [15:0] i, input logic [2:0] nzp, input int d,
                                  input int len, input int idx, input outs_t e);
    vec_t v;
    v.ir = i; v.nzp = nzp; v.d = d; v.len = len; v.idx = idx; v.exp = e;
    vecs.push_back(v);
  endfunction

  function automatic void push(input outs_t o, input bit br);
    rec_t r;
    r.o = o; r.br = br;
    exp_q.push_back(r);
  endfunction

  // Expected per-cycle strobe list for one whole instruction, fetch through completion.
  function automatic void build_exp(input logic [15:0] i, input int mw);
    outs_t o;
    logic [3:0] op;
    op = i[15:12];
    exp_q.delete();
    o = '0; o.ena_pc = 1; o.ld_mar = 1; o.ld_pc = 1; push(o, 0);
    for (int k = 0; k <= mw; k++) begin
      o = '0; o.sel_mdr = 1; o.ld_mdr = (k == mw); push(o, 0);
    end
    o = '0; o.ena_mdr = 1; o.ld_ir = 1; push(o, 0);
    o = '0; push(o, 0);
    o = '0;
    if (op == 4'h1 || op == 4'h5 || op == 4'h9) begin
      o.ena_alu = 1; o.reg_we = 1; o.dr = i[11:9]; o.sr1 = i[8:6]; o.sr2 = i[2:0];
      o.alu = (op == 4'h5) ? 2'd1 : (op == 4'h9) ? 2'd2 : 2'd0;
      push(o, 0);
    end else if (op == 4'h0) begin
      o.sel_pc = 2'd1; o.sel_eab2 = 2'd2; push(o, 1);
    end else if (op == 4'hC) begin
      o.ld_pc = 1; o.sel_pc = 2'd1; o.sel_eab1 = 1; o.sr1 = i[8:6]; push(o, 0);
    end else if (op == 4'hE) begin
      o.ena_marm = 1; o.sel_eab2 = 2'd2; o.reg_we = 1; o.dr = i[11:9]; push(o, 0);
    end else begin
      o.ena_marm = 1; o.ld_mar = 1;
      if (op == 4'h6 || op == 4'h7) begin
        o.sel_eab1 = 1; o.sel_eab2 = 2'd1; o.sr1 = i[8:6];
      end else begin
        o.sel_eab2 = 2'd2;
      end
      push(o, 0);
      if (op == 4'h3 || op == 4'h7) begin
        o = '0; o.sr1 = i[11:9]; o.alu = 2'd3; o.ena_alu = 1; o.ld_mdr = 1; push(o, 0);
        for (int k = 0; k <= mw; k++) begin
          o = '0; o.mem_we = 1; push(o, 0);
        end
      end else begin
        for (int k = 0; k <= mw; k++) begin
          o = '0; o.sel_mdr = 1; o.ld_mdr = (k == mw); push(o, 0);
        end
        o = '0; o.ena_mdr = 1; o.reg_we = 1; o.dr = i[11:9]; push(o, 0);
      end
    end
  endfunction

  task automatic reset_dut(input int d);
    @(negedge clk);
    rst[d] = 1'b1;
    #1 check("rst_zero", d, outs[d], '0);
    repeat (3) @(negedge clk);
    rst[d] = 1'b0;
  endtask

  // Runs one instruction from FETCH0 (entered at a negedge), records cycles until the next FETCH0.
  task automatic capture(input int d, input logic [15:0] i, input logic [2:0] nzp, output int len);
    ir[d] = i;
    {n[d], z[d], p[d]} = nzp;
    len = -1;
    for (int c = 0; c < 32; c++) begin
      #1 trace[c] = outs[d];
      if (c > 0 && trace[c].ena_pc && trace[c].ld_mar && trace[c].ld_pc) begin
        len = c;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic run_model(input int d, input logic [15:0] i);
    outs_t e;
    build_exp(i, (d == 1) ? 2 : 0);
    ir[d] = i;
    for (int k = 0; k < exp_q.size(); k++) begin
      {n[d], z[d], p[d]} = 3'($urandom);
      #1;
      e = exp_q[k].o;
      if (exp_q[k].br) e.ld_pc = (i[11] & n[d]) | (i[10] & z[d]) | (i[9] & p[d]);
      check($sformatf("rand_ir%h_c%0d", i, k), d, outs[d], e);
      check_int("bus_onehot", int'($onehot0({outs[d].ena_alu, outs[d].ena_marm,
                                              outs[d].ena_mdr, outs[d].ena_pc})), 1);
      @(negedge clk);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    outs_t e;
    outs_t fetch0;
    int len;
    logic [3:0] ops [10];
    ops = '{4'h1, 4'h5, 4'h9, 4'h0, 4'hC, 4'hE, 4'h2, 4'h3, 4'h6, 4'h7};

    for (int k = 0; k < 2; k++) begin
      rst[k] = 1'b1; ir[k] = 16'h0000; n[k] = 1'b0; z[k] = 1'b0; p[k] = 1'b0;
    end
    fetch0 = '0; fetch0.ena_pc = 1; fetch0.ld_mar = 1; fetch0.ld_pc = 1;

    e = '0; e.ena_alu = 1; e.reg_we = 1; e.dr = 1; e.sr1 = 2; e.sr2 = 3;
    add_vec(16'h1283, 3'b000, 0, 5, 4, e);
    e.alu = 2'd1;
    add_vec(16'h5283, 3'b000, 0, 5, 4, e);
    e = '0; e.ena_alu = 1; e.reg_we = 1; e.dr = 1; e.sr1 = 1; e.sr2 = 7; e.alu = 2'd2;
    add_vec(16'h927F, 3'b000, 0, 5, 4, e);
    e = '0; e.sel_pc = 2'd1; e.sel_eab2 = 2'd2;
    add_vec(16'h0A05, 3'b010, 0, 5, 4, e);
    add_vec(16'h0005, 3'b111, 0, 5, 4, e);
    e.ld_pc = 1;
    add_vec(16'h0A05, 3'b100, 0, 5, 4, e);
    add_vec(16'h0405, 3'b010, 0, 5, 4, e);
    e = '0; e.ld_pc = 1; e.sel_pc = 2'd1; e.sel_eab1 = 1; e.sr1 = 2;
    add_vec(16'hC080, 3'b000, 0, 5, 4, e);
    e = '0; e.ena_marm = 1; e.sel_eab2 = 2'd2; e.reg_we = 1; e.dr = 3;
    add_vec(16'hE605, 3'b000, 0, 5, 4, e);
    e = '0; e.ena_mdr = 1; e.reg_we = 1; e.dr = 2;
    add_vec(16'h2405, 3'b000, 1, 11, 10, e);
    add_vec(16'h2405, 3'b000, 0, 7, 6, e);
    e = '0; e.sel_mdr = 1;
    add_vec(16'h2405, 3'b000, 1, 11, 2, e);
    e.ld_mdr = 1;
    add_vec(16'h2405, 3'b000, 1, 11, 3, e);
    e = '0; e.ena_marm = 1; e.ld_mar = 1; e.sel_eab1 = 1; e.sel_eab2 = 2'd1; e.sr1 = 1;
    add_vec(16'h7A7F, 3'b000, 0, 7, 4, e);
    e = '0; e.sr1 = 5; e.alu = 2'd3; e.ena_alu = 1; e.ld_mdr = 1;
    add_vec(16'h7A7F, 3'b000, 0, 7, 5, e);
    e = '0; e.mem_we = 1;
    add_vec(16'h7A7F, 3'b000, 0, 7, 6, e);
    add_vec(16'h7A7F, 3'b000, 1, 11, 8, e);
    e = '0; e.ena_marm = 1; e.ld_mar = 1; e.sel_eab2 = 2'd2;
    add_vec(16'h3405, 3'b000, 0, 7, 4, e);

    for (int k = 0; k < vecs.size(); k++) begin
      reset_dut(vecs[k].d);
      capture(vecs[k].d, vecs[k].ir, vecs[k].nzp, len);
      check_int($sformatf("vec%0d_len", k), len, vecs[k].len);
      check($sformatf("vec%0d_out", k), vecs[k].d, trace[vecs[k].idx], vecs[k].exp);
    end

    // Reset asserted in the middle of a stretched MEMWR.
    reset_dut(1);
    ir[1] = 16'h7A7F;
    repeat (9) @(negedge clk);
    #1 check_int("memwr_pre", int'(outs[1].mem_we), 1);
    #1 rst[1] = 1'b1;
    #1 check("memwr_rst_async", 1, outs[1], '0);
    repeat (3) begin
      @(negedge clk);
      #1 check("memwr_rst_hold", 1, outs[1], '0);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    run_model(1, 16'h2405);

    // Reserved opcode halts until reset.
    reset_dut(0);
    ir[0] = 16'hD000;
    repeat (4) @(negedge clk);
    e = '0; e.halted = 1;
    for (int k = 0; k < 20; k++) begin
      #1 check($sformatf("halt_c%0d", k), 0, outs[0], e);
      @(negedge clk);
    end
    rst[0] = 1'b1;
    #1 check("halt_rst", 0, outs[0], '0);
    @(negedge clk);
    rst[0] = 1'b0;
    #1 check("halt_post_rst", 0, outs[0], fetch0);

    for (int d = 0; d < 2; d++) begin
      reset_dut(d);
      for (int k = 0; k < 40; k++) begin
        logic [3:0]  op;
        logic [11:0] lo;
        op = ops[$urandom_range(0, 9)];
        lo = 12'($urandom);
        run_model(d, {op, lo});
      end
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/lc3_sequencer.md
LC3_SEQUENCER -- requirements
Module: lc3_sequencer

Interface
REQ-001 Parameter MEM_WAIT, default 0, extra wait cycles added to every memory read or write state (0..15).
REQ-002 clk  input  1  single clock; all state advances on rising edge.
REQ-003 reset  input  1  asynchronous, active-high; forces the reset state immediately.
REQ-004 IR  input  16  current instruction register contents.
REQ-005 N, Z, P  input  1 each  condition codes from the NZP register.
REQ-006 aluControl  output  2  ALU operation: 00 ADD, 01 AND, 10 NOT, 11 PASS Ra.
REQ-007 enaALU, enaMARM, enaMDR, enaPC  output  1 each  bus driver enables.
REQ-008 selMAR  output  1  MAR mux select: 0 eabOut, 1 zero-extended IR[7:0].
REQ-009 selEAB1  output  1  EAB base select: 0 PC, 1 Ra.
REQ-010 selEAB2  output  2  EAB offset select: 00 zero, 01 sext IR[5:0], 10 sext IR[8:0], 11 sext IR[10:0].
REQ-011 ldPC, ldIR, ldMAR, ldMDR  output  1 each  register load strobes.
REQ-012 selPC  output  2  PC source: 00 PC+1, 01 eabOut, 10 Bus.
REQ-013 selMDR  output  1  MDR source: 0 Bus, 1 memory read data.
REQ-014 SR1, SR2, DR  output  3 each  register file read/write addresses.
REQ-015 regWE, memWE  output  1 each  register file and memory write enables; regWE also loads NZP.
REQ-016 halted  output  1  high while in HALT.

Function
REQ-017 The block SHALL be a Moore FSM: all outputs are decoded from registered state and IR; no outputs depend combinationally on N/Z/P except the BR state's ldPC.
REQ-018 Every output not listed for a state SHALL be 0; at most one bus enable SHALL be high in any cycle.
REQ-019 States: FETCH0, FETCH1, FETCH2, DECODE, EXEC_ALU, EXEC_BR, EXEC_JMP, EXEC_LEA, ADDR, MEMRD, WB, MDRLD, MEMWR, HALT.
REQ-020 FETCH0: enaPC, ldMAR, ldPC, selPC=00; next FETCH1.
REQ-021 FETCH1: ldMDR, selMDR=1; held MEM_WAIT+1 cycles via a wait counter (ldMDR asserted only in the last cycle); next FETCH2.
REQ-022 FETCH2: enaMDR, ldIR; next DECODE.
REQ-023 DECODE: no outputs; branch on IR[15:12]: 0001/0101/1001 EXEC_ALU, 0000 EXEC_BR, 1100 EXEC_JMP, 1110 EXEC_LEA, 0010/0110/0011/0111 ADDR, any other opcode HALT.
REQ-024 EXEC_ALU: enaALU, regWE, DR=IR[11:9], SR1=IR[8:6], SR2=IR[2:0], aluControl 00/01/10 for ADD/AND/NOT; next FETCH0.
REQ-025 EXEC_BR: ldPC=(IR[11]&N)|(IR[10]&Z)|(IR[9]&P), selPC=01, selEAB1=0, selEAB2=10; next FETCH0; BR with IR[11:9]=000 SHALL never load PC.
REQ-026 EXEC_JMP: ldPC, selPC=01, selEAB1=1, selEAB2=00, SR1=IR[8:6]; next FETCH0.
REQ-027 EXEC_LEA: enaMARM, selMAR=0, selEAB1=0, selEAB2=10, regWE, DR=IR[11:9]; next FETCH0.
REQ-028 ADDR: enaMARM, ldMAR, selMAR=0; LD/ST use selEAB1=0, selEAB2=10; LDR/STR use selEAB1=1, selEAB2=01, SR1=IR[8:6]; next MEMRD for loads, MDRLD for stores.
REQ-029 MEMRD: as FETCH1 timing; next WB. WB: enaMDR, regWE, DR=IR[11:9]; next FETCH0.
REQ-030 MDRLD: SR1=IR[11:9], aluControl=11, enaALU, ldMDR, selMDR=0; next MEMWR.
REQ-031 MEMWR: memWE held for MEM_WAIT+1 cycles; next FETCH0.
REQ-032 HALT: halted=1, all other outputs 0; stays until reset.
REQ-033 Cycle counts at MEM_WAIT=0: ALU/BR/JMP/LEA 5 cycles; LD/LDR/ST/STR 7 cycles; each memory state adds MEM_WAIT.

Reset
REQ-034 reset assertion SHALL force FETCH0 and clear the wait counter asynchronously, at any state including mid memory wait or HALT.
REQ-035 During reset all outputs SHALL be 0 except the FETCH0 decode, which is gated off until reset deasserts.

Verification
REQ-036 Reset held 3 cycles mid-MEMWR -> memWE drops to 0 asynchronously; first post-reset cycle shows FETCH0 (enaPC=ldMAR=ldPC=1).
REQ-037 IR=0x1283 (ADD R1,R2,R3), MEM_WAIT=0 -> cycle 5: enaALU=regWE=1, DR=1, SR1=2, SR2=3, aluControl=00; cycle 6 FETCH0.
REQ-038 IR=0x0A05 (BRnp), Z=1 -> ldPC=0 in EXEC_BR; with N=1 -> ldPC=1, selPC=01, selEAB2=10.
REQ-039 IR=0x2405 (LD R2), MEM_WAIT=2 -> FETCH1 and MEMRD each last 3 cycles with ldMDR only in the last; WB: DR=2, enaMDR=regWE=1; total 11 cycles.
REQ-040 IR=0x7A7F (STR R5,R1,#-1) -> ADDR selEAB1=1, selEAB2=01, SR1=1; MDRLD SR1=5, aluControl=11; MEMWR memWE=1 one cycle.
REQ-041 IR=0xD000 (reserved) -> HALT after DECODE, halted=1 indefinitely; reset returns to FETCH0.
